// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared FSM state, default sizes and slot map for bus_xfer
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRIVE   = 2'd2
    } bus_state_e;

    localparam int BUS_WIDTH = 17;
    localparam int BUS_NSRC  = 16;
    localparam int BUS_SEL_W = 4;

    localparam int SLOT_IR = 4;
    localparam int SLOT_AC = 5;
    localparam int SLOT_R1 = 7;
    localparam int SLOT_R2 = 8;
    localparam int SLOT_R3 = 9;
    localparam int SLOT_R4 = 10;
    localparam int SLOT_DM = 12;
    localparam int SLOT_IM = 13;

endpackage

// File: rtl/bus_src_mux.sv
// rtl/bus_src_mux.sv - combinational source slot selector with legality flag
module bus_src_mux #(
    parameter int WIDTH = 17,
    parameter int NSRC  = 16,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_en,
    output logic [WIDTH-1:0]      data,
    output logic                  legal
);

    // Out-of-range selects match no slot and therefore stay illegal with zero data.
    always_comb begin
        data  = '0;
        legal = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k) && src_en[k]) begin
                data  = src_data[k*WIDTH +: WIDTH];
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xfer.sv
// rtl/bus_xfer.sv - request/capture/drive bus transfer FSM; BUS_XFER_PARITY_EN adds bus_par
module bus_xfer
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = BUS_NSRC,
    parameter int SEL_W = BUS_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [SEL_W-1:0]      read_sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_en,
    input  logic                  ack,
    output logic [WIDTH-1:0]      busout,
    output logic                  bus_valid,
    output logic                  busy,
`ifdef BUS_XFER_PARITY_EN
    output logic                  bus_par,
`endif
    output logic                  sel_err
);

    bus_state_e       r_state;
    bus_state_e       w_state_nxt;
    logic [SEL_W-1:0] r_sel_q;
    logic [WIDTH-1:0] r_busout;
    logic             r_bus_valid;
    logic             r_sel_err;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_legal;
    logic             w_load_sel;
    logic             w_capture;
    logic             w_busy;

    bus_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_src_mux (
        .sel      (r_sel_q),
        .src_data (src_data),
        .src_en   (src_en),
        .data     (w_mux_data),
        .legal    (w_mux_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req) w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = DRIVE;
            DRIVE:   if (ack) w_state_nxt = req ? CAPTURE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // req is only honoured in IDLE or on the accepting edge of DRIVE.
    always_comb begin
        w_busy     = (r_state != IDLE);
        w_capture  = (r_state == CAPTURE);
        w_load_sel = req && ((r_state == IDLE) || (r_state == DRIVE && ack));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q     <= '0;
            r_busout    <= '0;
            r_bus_valid <= 1'b0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_load_sel) r_sel_q <= read_sel;
            if (w_capture) begin
                r_busout  <= w_mux_data;
                r_sel_err <= ~w_mux_legal;
            end
            r_bus_valid <= (w_state_nxt == DRIVE);
        end
    end

`ifdef BUS_XFER_PARITY_EN
    logic r_bus_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_par <= 1'b0;
        end else if (w_capture) begin
            r_bus_par <= ^w_mux_data;
        end
    end

    assign bus_par = r_bus_par;
`endif

    assign busout    = r_busout;
    assign bus_valid = r_bus_valid;
    assign sel_err   = r_sel_err;
    assign busy      = w_busy;

endmodule

// File: tb/tb_bus_xfer.sv
// tb/tb_bus_xfer.sv - self-checking bench for bus_xfer; BUS_XFER_PARITY_EN enables parity checks
module tb_bus_xfer;
    import bus_pkg::*;

    localparam int W  = BUS_WIDTH;
    localparam int NS = BUS_NSRC;
    localparam int SW = BUS_SEL_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic [SW-1:0]     read_sel;
    logic [NS*W-1:0]   src_data;
    logic [NS-1:0]     src_en;
    logic              ack;
    logic [W-1:0]      busout;
    logic              bus_valid;
    logic              busy;
    logic              sel_err;
`ifdef BUS_XFER_PARITY_EN
    logic              bus_par;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bus_xfer #(.WIDTH(W), .NSRC(NS), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .read_sel  (read_sel),
        .src_data  (src_data),
        .src_en    (src_en),
        .ack       (ack),
        .busout    (busout),
        .bus_valid (bus_valid),
        .busy      (busy),
`ifdef BUS_XFER_PARITY_EN
        .bus_par   (bus_par),
`endif
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a transfer yields the slot word only for an in-range populated slot, else zero with error.
    function automatic logic [W-1:0] ref_word(input logic [NS*W-1:0] d, input logic [NS-1:0] en, input int sel);
        if (sel < NS && en[sel]) return d[sel*W +: W];
        return '0;
    endfunction

    function automatic logic ref_err(input logic [NS-1:0] en, input int sel);
        return !(sel < NS && en[sel]);
    endfunction

    task automatic set_slot(input int k, input logic [W-1:0] v);
        src_data[k*W +: W] = v;
    endtask

    task automatic randomize_sources();
        for (int k = 0; k < NS; k++) src_data[k*W +: W] = W'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; ack = 1'b0; read_sel = '0;
        src_data = '0; src_en = '0;
        step(); step();
        n_checks++; if (busout !== '0)   begin n_errors++; $display("FAIL reset_busout got %h exp 0", busout); end
        n_checks++; if (bus_valid !== 0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", bus_valid); end
        n_checks++; if (busy !== 0)      begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (sel_err !== 0)   begin n_errors++; $display("FAIL reset_sel_err got %b exp 0", sel_err); end
`ifdef BUS_XFER_PARITY_EN
        n_checks++; if (bus_par !== 0)   begin n_errors++; $display("FAIL reset_par got %b exp 0", bus_par); end
`endif
    endtask

    task automatic test_basic();
        set_slot(SLOT_AC, 17'h0ABC);
        src_en[SLOT_AC] = 1'b1;
        rst = 1'b0; req = 1'b1; read_sel = SW'(SLOT_AC);
        step();
        req = 1'b0;
        n_checks++; if (busy !== 1)      begin n_errors++; $display("FAIL basic_busy_cap got %b exp 1", busy); end
        n_checks++; if (bus_valid !== 0) begin n_errors++; $display("FAIL basic_valid_cap got %b exp 0", bus_valid); end
        step();
        n_checks++; if (bus_valid !== 1)       begin n_errors++; $display("FAIL basic_valid got %b exp 1", bus_valid); end
        n_checks++; if (busout !== 17'h0ABC)   begin n_errors++; $display("FAIL basic_busout got %h exp 0abc", busout); end
        n_checks++; if (sel_err !== 0)         begin n_errors++; $display("FAIL basic_sel_err got %b exp 0", sel_err); end
        n_checks++; if (busy !== 1)            begin n_errors++; $display("FAIL basic_busy_drv got %b exp 1", busy); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (busy !== 0 || bus_valid !== 0) begin n_errors++; $display("FAIL basic_idle got busy=%b valid=%b exp 0 0", busy, bus_valid); end
        n_checks++; if (busout !== 17'h0ABC)   begin n_errors++; $display("FAIL basic_idle_hold got %h exp 0abc", busout); end
    endtask

    task automatic test_illegal();
        src_en[3] = 1'b0;
        set_slot(3, 17'h1FFFF);
        req = 1'b1; read_sel = 4'd3;
        step();
        req = 1'b0;
        step();
        n_checks++; if (bus_valid !== 1) begin n_errors++; $display("FAIL illegal_valid got %b exp 1", bus_valid); end
        n_checks++; if (busout !== '0)   begin n_errors++; $display("FAIL illegal_busout got %h exp 0", busout); end
        n_checks++; if (sel_err !== 1)   begin n_errors++; $display("FAIL illegal_sel_err got %b exp 1", sel_err); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (sel_err !== 1 || bus_valid !== 0) begin n_errors++; $display("FAIL illegal_idle got err=%b valid=%b exp 1 0", sel_err, bus_valid); end
    endtask

    task automatic test_hold();
        logic [W-1:0] exp;
        src_en[SLOT_R1] = 1'b1;
        set_slot(SLOT_R1, 17'h12345);
        exp = 17'h12345;
        req = 1'b1; read_sel = SW'(SLOT_R1);
        step();
        req = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            randomize_sources();
            req = i[0];
            read_sel = SW'(SLOT_DM);
            step();
            n_checks++; if (busout !== exp || bus_valid !== 1 || busy !== 1) begin
                n_errors++; $display("FAIL hold_%0d got busout=%h valid=%b exp %h 1", i, busout, bus_valid, exp);
            end
        end
        req = 1'b0; ack = 1'b1;
        step();
        ack = 1'b0;
        n_checks++; if (busy !== 0 || bus_valid !== 0) begin n_errors++; $display("FAIL hold_release got busy=%b valid=%b exp 0 0", busy, bus_valid); end
        step();
        n_checks++; if (busy !== 0) begin n_errors++; $display("FAIL hold_no_queue got busy=%b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        src_en = '1;
        set_slot(SLOT_IR, 17'h00F0F);
        set_slot(SLOT_IM, 17'h1C0DE);
        req = 1'b1; read_sel = SW'(SLOT_IR);
        step();
        req = 1'b0;
        step();
        ack = 1'b1; req = 1'b1; read_sel = SW'(SLOT_IM);
        step();
        ack = 1'b0; req = 1'b0;
        n_checks++; if (bus_valid !== 0 || busy !== 1) begin n_errors++; $display("FAIL b2b_gap got valid=%b busy=%b exp 0 1", bus_valid, busy); end
        step();
        n_checks++; if (bus_valid !== 1 || busout !== 17'h1C0DE) begin
            n_errors++; $display("FAIL b2b_word got valid=%b busout=%h exp 1 1c0de", bus_valid, busout);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset_abort();
        set_slot(SLOT_R2, 17'h0BEEF);
        src_en[SLOT_R2] = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            req = 1'b1; read_sel = SW'(SLOT_R2);
            step();
            req = 1'b0;
            if (ph == 1) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            n_checks++; if (busout !== '0 || bus_valid !== 0 || busy !== 0 || sel_err !== 0) begin
                n_errors++; $display("FAIL abort_%0d got busout=%h valid=%b busy=%b err=%b exp 0 0 0 0", ph, busout, bus_valid, busy, sel_err);
            end
            for (int i = 0; i < 3; i++) begin
                step();
                n_checks++; if (bus_valid !== 0 || busy !== 0) begin
                    n_errors++; $display("FAIL abort_quiet_%0d_%0d got valid=%b busy=%b exp 0 0", ph, i, bus_valid, busy);
                end
            end
        end
    endtask

`ifdef BUS_XFER_PARITY_EN
    task automatic test_parity();
        logic [W-1:0] vals [2];
        logic         pars [2];
        vals[0] = 17'h00007; pars[0] = 1'b1;
        vals[1] = 17'h00003; pars[1] = 1'b0;
        src_en[SLOT_R3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_slot(SLOT_R3, vals[i]);
            req = 1'b1; read_sel = SW'(SLOT_R3);
            step();
            req = 1'b0;
            step();
            n_checks++; if (busout !== vals[i] || bus_par !== pars[i]) begin
                n_errors++; $display("FAIL parity_%0d got busout=%h par=%b exp %h %b", i, busout, bus_par, vals[i], pars[i]);
            end
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] exp_w;
        logic         exp_e;
        int           sel;
        logic         chain;
        chain = 1'b0;
        sel   = 0;
        for (int t = 0; t < 40; t++) begin
            randomize_sources();
            src_en = NS'($urandom);
            if (!chain) begin
                sel = $urandom_range(0, NS - 1);
                ack = 1'($urandom);
                req = 1'b1; read_sel = SW'(sel);
                step();
            end
            req = 1'b0; ack = 1'b0;
            exp_w = ref_word(src_data, src_en, sel);
            exp_e = ref_err(src_en, sel);
            step();
            n_checks++; if (bus_valid !== 1 || busout !== exp_w || sel_err !== exp_e) begin
                n_errors++; $display("FAIL rand_%0d sel=%0d got valid=%b busout=%h err=%b exp 1 %h %b", t, sel, bus_valid, busout, sel_err, exp_w, exp_e);
            end
`ifdef BUS_XFER_PARITY_EN
            n_checks++; if (bus_par !== ^exp_w) begin n_errors++; $display("FAIL rand_par_%0d got %b exp %b", t, bus_par, ^exp_w); end
`endif
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                randomize_sources();
                req = 1'($urandom); read_sel = SW'($urandom);
                step();
                n_checks++; if (busout !== exp_w || bus_valid !== 1) begin
                    n_errors++; $display("FAIL rand_hold_%0d got busout=%h valid=%b exp %h 1", t, busout, bus_valid, exp_w);
                end
            end
            chain = 1'($urandom);
            ack = 1'b1; req = chain;
            if (chain) begin
                sel = $urandom_range(0, NS - 1);
                read_sel = SW'(sel);
            end
            step();
            n_checks++; if (bus_valid !== 0 || busy !== chain) begin
                n_errors++; $display("FAIL rand_ack_%0d got valid=%b busy=%b exp 0 %b", t, bus_valid, busy, chain);
            end
        end
        req = 1'b0; ack = 1'b0;
        if (chain) begin
            step();
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_abort();
`ifdef BUS_XFER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
